// File: rtl/paddle2_input_conditioner.sv
// paddle2_input_conditioner
// Turns two raw, bouncy, asynchronous push-buttons into clean one-cycle step
// requests for the right-hand paddle. Each button goes through a 2-FF
// synchroniser, polarity correction and an independent debouncer. The two
// debounced levels are then resolved for mutual exclusion, and at most one
// step per frame_tick is emitted.
//
// Optional feature: define PADDLE2_ACCEL_EN to add hold acceleration. The
// first ACCEL_TICKS ticks of a continuous hold step at half rate, and every
// tick steps after that. Without the macro, every qualifying tick steps.
//
// Ports:
//   clock         in   system/pixel clock
//   reset         in   asynchronous, active-high reset
//   btn_up_raw    in   raw up button, asynchronous to clock
//   btn_down_raw  in   raw down button, asynchronous to clock
//   frame_tick    in   one-cycle strobe once per frame, synchronous to clock
//   paddle2_up    out  one-cycle step-up request
//   paddle2_down  out  one-cycle step-down request
//   up_held       out  debounced up level
//   down_held     out  debounced down level
//   conflict      out  high while both debounced levels are 1
module paddle2_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES   = 250000,
  parameter bit          BUTTON_ACTIVE_LOW = 1'b0,
  parameter int unsigned ACCEL_TICKS       = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_up_raw,
  input  logic btn_down_raw,
  input  logic frame_tick,
  output logic paddle2_up,
  output logic paddle2_down,
  output logic up_held,
  output logic down_held,
  output logic conflict
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  // Raw level of a released button. The synchroniser resets to this level so
  // that, after polarity correction, it reads as released.
  localparam logic [1:0] RAW_RELEASED = {2{BUTTON_ACTIVE_LOW}};

  // Bit 1 is the up button and bit 0 is the down button throughout.
  logic [1:0]       sync1;
  logic [1:0]       sync2;
  logic [1:0]       sync_pol;
  logic [1:0]       stable;
  logic [1:0]       stable_next;
  logic [CNT_W-1:0] db_cnt [2];
  logic [1:0]       dir;
  logic             step_ok;

  assign sync_pol  = sync2 ^ RAW_RELEASED;
  assign up_held   = stable[1];
  assign down_held = stable[0];

  // The resolved direction comes from the registered levels, so a tick that
  // arrives in the same cycle as a flip still sees the pre-flip value.
  assign dir = {stable[1] & ~stable[0], stable[0] & ~stable[1]};

  // Stable level flips on the last of DEBOUNCE_CYCLES consecutive differing cycles.
  always_comb begin
    stable_next = stable;
    for (int b = 0; b < 2; b++) begin
      if ((sync_pol[b] != stable[b]) && (db_cnt[b] == CNT_W'(DEBOUNCE_CYCLES - 1))) begin
        stable_next[b] = sync_pol[b];
      end
    end
  end

  // Synchroniser, debounce counters and stable levels.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1    <= RAW_RELEASED;
      sync2    <= RAW_RELEASED;
      stable   <= 2'b00;
      conflict <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        db_cnt[b] <= '0;
      end
    end else begin
      sync1    <= {btn_up_raw, btn_down_raw};
      sync2    <= sync1;
      stable   <= stable_next;
      conflict <= &stable_next;
      for (int b = 0; b < 2; b++) begin
        if ((sync_pol[b] == stable[b]) || (stable_next[b] != stable[b])) begin
          db_cnt[b] <= '0;
        end else begin
          db_cnt[b] <= db_cnt[b] + CNT_W'(1);
        end
      end
    end
  end

`ifdef PADDLE2_ACCEL_EN
  localparam int unsigned HOLD_W = $clog2(ACCEL_TICKS + 1);

  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] eff_cnt;
  logic              phase;
  logic              eff_phase;
  logic [1:0]        prev_dir;

  // The hold restarts when the direction goes idle, changes, or enters conflict.
  always_comb begin
    eff_cnt   = hold_cnt;
    eff_phase = phase;
    if ((dir == 2'b00) || (dir != prev_dir)) begin
      eff_cnt   = '0;
      eff_phase = 1'b0;
    end
    step_ok = (eff_cnt == HOLD_W'(ACCEL_TICKS)) || !eff_phase;
  end

  // Hold tick counter saturates at ACCEL_TICKS.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_cnt <= '0;
      phase    <= 1'b0;
      prev_dir <= 2'b00;
    end else begin
      prev_dir <= dir;
      if (frame_tick && (dir != 2'b00)) begin
        hold_cnt <= (eff_cnt == HOLD_W'(ACCEL_TICKS)) ? eff_cnt : eff_cnt + HOLD_W'(1);
        phase    <= ~eff_phase;
      end else begin
        hold_cnt <= eff_cnt;
        phase    <= eff_phase;
      end
    end
  end
`else
  assign step_ok = 1'b1;

  // ACCEL_TICKS only shapes the acceleration logic. This empty block keeps it
  // referenced in the default build.
  if (ACCEL_TICKS == 0) begin : g_accel_param_ref
  end
`endif

  // Each step is a one-cycle pulse in the cycle after the qualifying frame tick.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      paddle2_up   <= 1'b0;
      paddle2_down <= 1'b0;
    end else begin
      paddle2_up   <= frame_tick & dir[1] & step_ok;
      paddle2_down <= frame_tick & dir[0] & step_ok;
    end
  end

endmodule

// File: tb/tb_paddle2_input_conditioner.sv
module tb_paddle2_input_conditioner;

  localparam int DEB = 4;
  localparam int ACC = 3;

  logic clock = 1'b0;
  logic reset;
  logic pr_up, pr_dn;     // logical "pressed" stimulus
  logic frame_tick;

  // Instance a: active-high buttons. Instance b: active-low, same presses.
  logic a_up, a_dn, a_hu, a_hd, a_cf;
  logic b_up, b_dn, b_hu, b_hd, b_cf;
  logic b_up_raw, b_dn_raw;
  assign b_up_raw = ~pr_up;
  assign b_dn_raw = ~pr_dn;

  paddle2_input_conditioner #(.DEBOUNCE_CYCLES(DEB), .BUTTON_ACTIVE_LOW(1'b0), .ACCEL_TICKS(ACC)) u_a (
    .clock(clock), .reset(reset), .btn_up_raw(pr_up), .btn_down_raw(pr_dn),
    .frame_tick(frame_tick), .paddle2_up(a_up), .paddle2_down(a_dn),
    .up_held(a_hu), .down_held(a_hd), .conflict(a_cf));

  paddle2_input_conditioner #(.DEBOUNCE_CYCLES(DEB), .BUTTON_ACTIVE_LOW(1'b1), .ACCEL_TICKS(ACC)) u_b (
    .clock(clock), .reset(reset), .btn_up_raw(b_up_raw), .btn_down_raw(b_dn_raw),
    .frame_tick(frame_tick), .paddle2_up(b_up), .paddle2_down(b_dn),
    .up_held(b_hu), .down_held(b_hd), .conflict(b_cf));

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;
  bit run_cmp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a level flips once the synchronised press has disagreed
  // with it for DEB straight cycles. Steps are paced by a hold-tick index k:
  // with acceleration, tick k steps when k-1 is even or k-1 >= ACC.
  logic [1:0] m_s1, m_s2, m_held;
  int         m_run [2];
  logic       m_conf, m_pu, m_pd;
  int         m_k;
  logic [1:0] m_prev;
  logic [1:0] t_held, t_dir;
  int         t_run [2];
  int         t_k;
  bit         t_ok;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_s1 <= '0; m_s2 <= '0; m_held <= '0; m_run[0] <= 0; m_run[1] <= 0;
      m_conf <= 1'b0; m_pu <= 1'b0; m_pd <= 1'b0; m_k <= 0; m_prev <= '0;
    end else begin
      t_held = m_held;
      for (int b = 0; b < 2; b++) begin
        t_run[b] = (m_s2[b] != m_held[b]) ? m_run[b] + 1 : 0;
        if (t_run[b] == DEB) begin
          t_held[b] = m_s2[b];
          t_run[b]  = 0;
        end
      end
      t_dir = {m_held[1] & ~m_held[0], m_held[0] & ~m_held[1]};
      t_k   = (t_dir != 2'b00 && t_dir == m_prev) ? m_k : 0;
      t_ok  = 1'b1;
      if (frame_tick && t_dir != 2'b00) begin
        t_k++;
`ifdef PADDLE2_ACCEL_EN
        t_ok = ((t_k - 1) >= ACC) || (((t_k - 1) % 2) == 0);
`endif
      end
      m_s1 <= {pr_up, pr_dn};
      m_s2 <= m_s1;
      m_held <= t_held;
      m_run[0] <= t_run[0];
      m_run[1] <= t_run[1];
      m_conf <= &t_held;
      m_pu <= frame_tick & t_dir[1] & t_ok;
      m_pd <= frame_tick & t_dir[0] & t_ok;
      m_k <= t_k;
      m_prev <= t_dir;
    end
  end

  // Per-cycle comparison of both instances against the model.
  int cnt_up = 0, cnt_dn = 0;
  always @(negedge clock) begin
    if (run_cmp) begin
      chk("a_up", 32'(a_up), 32'(m_pu));
      chk("a_down", 32'(a_dn), 32'(m_pd));
      chk("a_up_held", 32'(a_hu), 32'(m_held[1]));
      chk("a_down_held", 32'(a_hd), 32'(m_held[0]));
      chk("a_conflict", 32'(a_cf), 32'(m_conf));
      chk("b_up", 32'(b_up), 32'(m_pu));
      chk("b_down", 32'(b_dn), 32'(m_pd));
      chk("b_up_held", 32'(b_hu), 32'(m_held[1]));
      chk("b_down_held", 32'(b_hd), 32'(m_held[0]));
      chk("b_conflict", 32'(b_cf), 32'(m_conf));
      cnt_up += int'(a_up);
      cnt_dn += int'(a_dn);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic tick_pulse();
    frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
  endtask

  int base_up, base_dn;
  int exp_steps5, exp_accel8;

  initial begin
`ifdef PADDLE2_ACCEL_EN
    exp_steps5 = 4;
    exp_accel8 = 7;
`else
    exp_steps5 = 5;
    exp_accel8 = 8;
`endif
    reset = 1'b0; pr_up = 1'b0; pr_dn = 1'b0; frame_tick = 1'b0;
    #2 reset = 1'b1;
    #1 run_cmp = 1'b1;
    chk("reset_up_held", 32'(a_hu), 32'd0);
    chk("reset_b_down_held", 32'(b_hd), 32'd0);
    cyc(3);
    reset = 1'b0;
    cyc(5);

    // Debounce latency: 6 clocks from the raw edge.
    pr_up = 1'b1;
    cyc(5);
    chk("debounce_not_yet", 32'(a_hu), 32'd0);
    cyc(1);
    chk("debounce_rise", 32'(a_hu), 32'd1);
    chk("debounce_rise_b", 32'(b_hu), 32'd1);

    // Stepping: 5 ticks spaced 20 clocks apart.
    base_up = cnt_up; base_dn = cnt_dn;
    for (int t = 0; t < 5; t++) begin
      tick_pulse();
      if (t == 0) chk("step_pulse_after_tick", 32'(a_up), 32'd1);
      cyc(1);
      if (t == 0) chk("step_pulse_width", 32'(a_up), 32'd0);
      cyc(18);
    end
    chk("step_count_up", 32'(cnt_up - base_up), 32'(exp_steps5));
    chk("step_count_down", 32'(cnt_dn - base_dn), 32'd0);

    // Release, then a 3-clock glitch that must be ignored.
    pr_up = 1'b0;
    cyc(10);
    chk("release_up_held", 32'(a_hu), 32'd0);
    pr_up = 1'b1;
    cyc(3);
    pr_up = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      chk("glitch_ignored", 32'(a_hu), 32'd0);
    end

    // Conflict: both held, 4 ticks, no steps.
    pr_up = 1'b1; pr_dn = 1'b1;
    cyc(10);
    chk("conflict_level", 32'(a_cf), 32'd1);
    base_up = cnt_up; base_dn = cnt_dn;
    for (int t = 0; t < 4; t++) begin
      tick_pulse();
      cyc(19);
    end
    chk("conflict_no_steps", 32'((cnt_up - base_up) + (cnt_dn - base_dn)), 32'd0);
    pr_up = 1'b0;
    cyc(10);
    chk("conflict_cleared", 32'(a_cf), 32'd0);
    tick_pulse();
    chk("down_after_conflict", 32'(a_dn), 32'd1);
    chk("down_after_conflict_b", 32'(b_dn), 32'd1);
    cyc(1);
    pr_dn = 1'b0;
    cyc(10);

    // Hold up for 8 ticks.
    pr_up = 1'b1;
    cyc(10);
    base_up = cnt_up;
    for (int t = 0; t < 8; t++) begin
      tick_pulse();
      cyc(19);
    end
    chk("accel_count", 32'(cnt_up - base_up), 32'(exp_accel8));

    // Asynchronous reset in the middle of a hold and a down debounce.
    tick_pulse();
    pr_dn = 1'b1;
    cyc(2);
    reset = 1'b1;
    #1;
    chk("reset_async_up_held", 32'(a_hu), 32'd0);
    chk("reset_async_step", 32'(a_up | a_dn), 32'd0);
    chk("reset_async_b_held", 32'(b_hu | b_hd), 32'd0);
    pr_up = 1'b0; pr_dn = 1'b0;
    cyc(3);
    reset = 1'b0;
    base_up = cnt_up; base_dn = cnt_dn;
    for (int t = 0; t < 10; t++) begin
      tick_pulse();
      cyc(19);
    end
    chk("idle_no_steps", 32'((cnt_up - base_up) + (cnt_dn - base_dn)), 32'd0);
    chk("idle_held", 32'(a_hu | a_hd | b_hu | b_hd), 32'd0);

    run_cmp = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
